cpu_controller: RTL and testbench

Multi-cycle control FSM for the branch-capable Simple RISC Machine.
- Consumes decoded fields (opcode, op, cond) from the instruction decoder and Z/N/V status from the datapath.
- Sequences fetch, PC update, register-file reads and writes, ALU, memory and branch operations.
- Drives every load, select and write strobe of the datapath, program counter, instruction register, address register and memory interface.

---
 rtl/cpu_controller.sv | 182 ++++++++++++++++++
 tb/tb_cpu_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// ============================================================================
// Module   : cpu_controller
// Brief    : Multi-cycle control FSM for the branch-capable Simple RISC Machine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller #(
    parameter int STATE_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [3:0] vsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic [1:0] pc_sel,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    localparam logic [STATE_W-1:0] c_rst   = STATE_W'(0);
    localparam logic [STATE_W-1:0] c_if1   = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_if2   = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_upd   = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_dec   = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_wimm  = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_geta  = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_getb  = STATE_W'(7);
    localparam logic [STATE_W-1:0] c_aluz  = STATE_W'(8);
    localparam logic [STATE_W-1:0] c_alu   = STATE_W'(9);
    localparam logic [STATE_W-1:0] c_wrd   = STATE_W'(10);
    localparam logic [STATE_W-1:0] c_cmps  = STATE_W'(11);
    localparam logic [STATE_W-1:0] c_addr  = STATE_W'(12);
    localparam logic [STATE_W-1:0] c_laddr = STATE_W'(13);
    localparam logic [STATE_W-1:0] c_mrd   = STATE_W'(14);
    localparam logic [STATE_W-1:0] c_wmem  = STATE_W'(15);
    localparam logic [STATE_W-1:0] c_getbd = STATE_W'(16);
    localparam logic [STATE_W-1:0] c_pass  = STATE_W'(17);
    localparam logic [STATE_W-1:0] c_mwr   = STATE_W'(18);
    localparam logic [STATE_W-1:0] c_br    = STATE_W'(19);
    localparam logic [STATE_W-1:0] c_link  = STATE_W'(20);
    localparam logic [STATE_W-1:0] c_bjmp  = STATE_W'(21);
    localparam logic [STATE_W-1:0] c_cjmp  = STATE_W'(22);
    localparam logic [STATE_W-1:0] c_halt  = STATE_W'(23);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic               w_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_rst;
        else        r_state <= w_next;
    end

    always_comb begin
        w_taken = 1'b0;
        case (cond)
            3'b000:  w_taken = 1'b1;
            3'b001:  w_taken = Z;
            3'b010:  w_taken = ~Z;
            3'b011:  w_taken = N ^ V;
            3'b100:  w_taken = (N ^ V) | Z;
            default: w_taken = 1'b0;
        endcase
    end

    // opcode/op come from the IR, so they stay stable for the whole instruction
    // and shared states (GETA, GETB, LADDR, PASS, LINK) branch on them.
    always_comb begin
        w_next = c_rst;
        case (r_state)
            c_rst:   w_next = c_if1;
            c_if1:   w_next = c_if2;
            c_if2:   w_next = c_upd;
            c_upd:   w_next = c_dec;
            c_dec: begin
                casez ({opcode, op})
                    5'b110_10:             w_next = c_wimm;
                    5'b110_00, 5'b101_11:  w_next = c_getb;
                    5'b101_00, 5'b101_10,
                    5'b101_01, 5'b011_00,
                    5'b100_00:             w_next = c_geta;
                    5'b001_00:             w_next = c_br;
                    5'b010_11, 5'b010_10:  w_next = c_link;
                    5'b010_00:             w_next = c_getbd;
                    5'b111_??:             w_next = c_halt;
                    default:               w_next = c_if1;
                endcase
            end
            c_geta:  w_next = (opcode == 3'b101) ? c_getb : c_addr;
            c_getb: begin
                if (opcode != 3'b101 || op == 2'b11) w_next = c_aluz;
                else if (op == 2'b01)                w_next = c_cmps;
                else                                 w_next = c_alu;
            end
            c_aluz:  w_next = c_wrd;
            c_alu:   w_next = c_wrd;
            c_wrd:   w_next = c_if1;
            c_cmps:  w_next = c_if1;
            c_wimm:  w_next = c_if1;
            c_addr:  w_next = c_laddr;
            c_laddr: w_next = (opcode == 3'b011) ? c_mrd : c_getbd;
            c_mrd:   w_next = c_wmem;
            c_wmem:  w_next = c_if1;
            c_getbd: w_next = c_pass;
            c_pass:  w_next = (opcode == 3'b100) ? c_mwr : c_cjmp;
            c_mwr:   w_next = c_if1;
            c_br:    w_next = c_if1;
            c_link:  w_next = (op == 2'b11) ? c_bjmp : c_getbd;
            c_bjmp:  w_next = c_if1;
            c_cjmp:  w_next = c_if1;
            c_halt:  w_next = c_halt;
            default: w_next = c_rst;
        endcase
    end

    always_comb begin
        nsel      = 3'b000;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = 4'b0000;
        write     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        pc_sel    = 2'b00;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = 2'b00;
        halted    = 1'b0;
        case (r_state)
            c_rst:   begin reset_pc = 1'b1; load_pc = 1'b1; end
            c_if1:   begin addr_sel = 1'b1; mem_cmd = 2'b01; end
            c_if2:   begin addr_sel = 1'b1; mem_cmd = 2'b01; load_ir = 1'b1; end
            c_upd:   load_pc = 1'b1;
            c_wimm:  begin nsel = 3'b001; vsel = 4'b0100; write = 1'b1; end
            c_geta:  begin nsel = 3'b001; loada = 1'b1; end
            c_getb:  begin nsel = 3'b100; loadb = 1'b1; end
            c_aluz:  begin asel = 1'b1; loadc = 1'b1; end
            c_alu:   loadc = 1'b1;
            c_wrd:   begin nsel = 3'b010; vsel = 4'b0001; write = 1'b1; end
            c_cmps:  loads = 1'b1;
            c_addr:  begin bsel = 1'b1; loadc = 1'b1; end
            c_laddr: load_addr = 1'b1;
            c_mrd:   mem_cmd = 2'b01;
            c_wmem:  begin mem_cmd = 2'b01; nsel = 3'b010; vsel = 4'b1000; write = 1'b1; end
            c_getbd: begin nsel = 3'b010; loadb = 1'b1; end
            c_pass:  begin asel = 1'b1; loadc = 1'b1; end
            c_mwr:   mem_cmd = 2'b10;
            c_br:    begin pc_sel = 2'b01; load_pc = w_taken; end
            c_link:  begin nsel = 3'b001; vsel = 4'b0010; write = 1'b1; end
            c_bjmp:  begin load_pc = 1'b1; pc_sel = 2'b01; end
            c_cjmp:  begin load_pc = 1'b1; pc_sel = 2'b10; end
            c_halt:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module   : tb_cpu_controller
// Brief    : Directed vector bench for the cpu_controller FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic [2:0] cond = 3'b000;
    logic       Z = 1'b0, N = 1'b0, V = 1'b0;
    logic [2:0] nsel;
    logic       loada, loadb, loadc, loads, asel, bsel;
    logic [3:0] vsel;
    logic       write, load_ir, load_pc, reset_pc;
    logic [1:0] pc_sel;
    logic       addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic       halted;

    cpu_controller #(.STATE_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .Z(Z), .N(N), .V(V), .nsel(nsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
        .write(write), .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
        .pc_sel(pc_sel), .addr_sel(addr_sel), .load_addr(load_addr),
        .mem_cmd(mem_cmd), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [23:0] w_out;
    assign w_out = {nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write,
                    load_ir, load_pc, reset_pc, pc_sel, addr_sel, load_addr,
                    mem_cmd, halted};

    localparam logic [23:0] c_halt  = 24'd1 << 0;
    localparam logic [23:0] c_mrd   = 24'd1 << 1;
    localparam logic [23:0] c_mwr   = 24'd2 << 1;
    localparam logic [23:0] c_asel_pc = 24'd1 << 4;
    localparam logic [23:0] c_prel  = 24'd1 << 5;
    localparam logic [23:0] c_pc_c  = 24'd2 << 5;
    localparam logic [23:0] c_rpc   = 24'd1 << 7;
    localparam logic [23:0] c_lpc   = 24'd1 << 8;
    localparam logic [23:0] c_lir   = 24'd1 << 9;
    localparam logic [23:0] c_wr    = 24'd1 << 10;
    localparam logic [23:0] c_v_c   = 24'd1 << 11;
    localparam logic [23:0] c_v_pc  = 24'd2 << 11;
    localparam logic [23:0] c_v_imm = 24'd4 << 11;
    localparam logic [23:0] c_v_mem = 24'd8 << 11;
    localparam logic [23:0] c_lds   = 24'd1 << 17;
    localparam logic [23:0] c_ldb   = 24'd1 << 19;
    localparam logic [23:0] c_lda   = 24'd1 << 20;
    localparam logic [23:0] c_n_rn  = 24'd1 << 21;
    localparam logic [23:0] c_n_rd  = 24'd2 << 21;
    localparam logic [23:0] c_n_rm  = 24'd4 << 21;

    localparam logic [23:0] c_w_rst  = c_rpc | c_lpc;
    localparam logic [23:0] c_w_if1  = c_asel_pc | c_mrd;
    localparam logic [23:0] c_w_geta = c_n_rn | c_lda;
    localparam logic [23:0] c_w_getb = c_n_rm | c_ldb;
    localparam logic [23:0] c_w_wrd  = c_n_rd | c_v_c | c_wr;
    localparam logic [23:0] c_w_link = c_n_rn | c_v_pc | c_wr;

    typedef struct {
        string       name;
        logic [2:0]  opc;
        logic [1:0]  opf;
        logic [2:0]  cnd;
        logic        z, n, v;
        int          cyc;
        logic [23:0] first;
        logic [23:0] last;
    } vec_t;

    vec_t tv[21];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [23:0] rec[32];

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h want %06h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_held", w_out, c_w_rst);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("if1_after_reset", w_out, c_w_if1);
    endtask

    task automatic step(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic run_vec(input int i);
        int  k;
        bit  done;
        opcode = tv[i].opc; op = tv[i].opf; cond = tv[i].cnd;
        Z = tv[i].z; N = tv[i].n; V = tv[i].v;
        rec[0] = w_out;
        k = 0;
        done = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
            rec[k] = w_out;
            if (w_out === c_w_if1) done = 1;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no IF1 within 20 cycles want %0d", tv[i].name, tv[i].cyc);
            do_reset();
        end else begin
            chk_int({tv[i].name, "_cycles"}, k, tv[i].cyc);
            if (i == 0) begin
                chk("if2", rec[1], c_w_if1 | c_lir);
                chk("upd", rec[2], c_lpc);
                chk("dec", rec[3], 24'd0);
            end
            chk({tv[i].name, "_first"}, rec[4], tv[i].first);
            chk({tv[i].name, "_last"}, rec[k-1], tv[i].last);
        end
    endtask

    initial begin
        tv[0]  = '{"mov_imm", 3'b110, 2'b10, 3'b000, 0, 0, 0, 5,  c_n_rn | c_v_imm | c_wr, c_n_rn | c_v_imm | c_wr};
        tv[1]  = '{"mov_reg", 3'b110, 2'b00, 3'b000, 0, 0, 0, 7,  c_w_getb, c_w_wrd};
        tv[2]  = '{"add",     3'b101, 2'b00, 3'b000, 0, 0, 0, 8,  c_w_geta, c_w_wrd};
        tv[3]  = '{"and",     3'b101, 2'b10, 3'b000, 0, 0, 0, 8,  c_w_geta, c_w_wrd};
        tv[4]  = '{"mvn",     3'b101, 2'b11, 3'b000, 0, 0, 0, 7,  c_w_getb, c_w_wrd};
        tv[5]  = '{"cmp",     3'b101, 2'b01, 3'b000, 0, 0, 0, 7,  c_w_geta, c_lds};
        tv[6]  = '{"ldr",     3'b011, 2'b00, 3'b000, 0, 0, 0, 9,  c_w_geta, c_mrd | c_n_rd | c_v_mem | c_wr};
        tv[7]  = '{"str",     3'b100, 2'b00, 3'b000, 0, 0, 0, 10, c_w_geta, c_mwr};
        tv[8]  = '{"b",       3'b001, 2'b00, 3'b000, 0, 0, 0, 5,  c_prel | c_lpc, c_prel | c_lpc};
        tv[9]  = '{"beq_t",   3'b001, 2'b00, 3'b001, 1, 0, 0, 5,  c_prel | c_lpc, c_prel | c_lpc};
        tv[10] = '{"beq_n",   3'b001, 2'b00, 3'b001, 0, 0, 0, 5,  c_prel, c_prel};
        tv[11] = '{"bne_t",   3'b001, 2'b00, 3'b010, 0, 1, 1, 5,  c_prel | c_lpc, c_prel | c_lpc};
        tv[12] = '{"blt_n",   3'b001, 2'b00, 3'b011, 0, 1, 1, 5,  c_prel, c_prel};
        tv[13] = '{"blt_t",   3'b001, 2'b00, 3'b011, 0, 1, 0, 5,  c_prel | c_lpc, c_prel | c_lpc};
        tv[14] = '{"ble_t",   3'b001, 2'b00, 3'b100, 1, 0, 0, 5,  c_prel | c_lpc, c_prel | c_lpc};
        tv[15] = '{"ble_n",   3'b001, 2'b00, 3'b100, 0, 0, 0, 5,  c_prel, c_prel};
        tv[16] = '{"bc101_n", 3'b001, 2'b00, 3'b101, 1, 1, 0, 5,  c_prel, c_prel};
        tv[17] = '{"bl",      3'b010, 2'b11, 3'b000, 0, 0, 0, 6,  c_w_link, c_lpc | c_prel};
        tv[18] = '{"bx",      3'b010, 2'b00, 3'b000, 0, 0, 0, 7,  c_n_rd | c_ldb, c_lpc | c_pc_c};
        tv[19] = '{"blx",     3'b010, 2'b10, 3'b000, 0, 0, 0, 8,  c_w_link, c_lpc | c_pc_c};
        tv[20] = '{"undef",   3'b000, 2'b00, 3'b000, 0, 0, 0, 4,  c_w_if1, 24'd0};

        reset = 1'b0;
        #2;
        chk("async_reset", w_out, c_w_rst);
        do_reset();

        for (int i = 0; i < 21; i++) run_vec(i);

        // Reset asserted mid-LDR while the memory read is in flight.
        opcode = 3'b011; op = 2'b00; cond = 3'b000;
        step(7);
        chk("ldr_mrd", w_out, c_mrd);
        #2 reset = 1'b0;
        #1 chk("ldr_abort", w_out, c_w_rst);
        do_reset();

        // HALT holds with no strobes until reset.
        opcode = 3'b111; op = 2'b00;
        step(4);
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", w_out, c_halt);
            step(1);
        end
        #3 reset = 1'b0;
        #1 chk("halt_abort", w_out, c_w_rst);
        opcode = 3'b110; op = 2'b10;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
